decoder_r_insn: RTL and testbench

//  Control decoder for RV32I R-type (OP, opcode 7'b0110011) instructions in the

---
 rtl/decoder_r_insn.sv | 72 +++++++
 tb/tb_decoder_r_insn.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/decoder_r_insn.sv
// RV32I R-type control decoder: datapath selects, gated rd/mem write clocks, field extraction, illegal detect.
// Zero latency (combinational from INSN); only illegal_seen is registered. No backpressure.
module decoder_r_insn #(
  parameter logic [6:0] OPCODE_R = 7'b0110011
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] INSN,
  output logic        sub_sra,
  output logic        addr_sel,
  output logic        pc_next_sel,
  output logic        pc_alu_sel,
  output logic        rd_clk,
  output logic        mem_clk,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  output logic [4:0]  rd_addr,
  output logic [2:0]  alu_op,
  output logic        illegal,
  output logic        illegal_seen
);

  logic [6:0] funct7;
  logic [2:0] funct3;
  logic       legal;
  logic       wr_en;
  logic       illegal_seen_q;
  logic       illegal_seen_d;

  assign funct7   = INSN[31:25];
  assign funct3   = INSN[14:12];
  assign rs1_addr = INSN[19:15];
  assign rs2_addr = INSN[24:20];
  assign rd_addr  = INSN[11:7];
  assign alu_op   = funct3;

  // The alternate funct7 is only defined for SUB and SRA.
  always_comb begin
    legal = 1'b0;
    if (INSN[6:0] == OPCODE_R) begin
      if (funct7 == 7'b0000000) begin
        legal = 1'b1;
      end else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) begin
        legal = 1'b1;
      end
    end
  end

  assign illegal     = ~legal;
  assign sub_sra     = legal & INSN[30];
  assign addr_sel    = 1'b0;
  assign pc_next_sel = 1'b0;
  assign pc_alu_sel  = 1'b0;
  assign mem_clk     = 1'b0;

  // INSN only changes while CLK is low, so this gate cannot glitch.
  assign wr_en  = legal & ~RST & (rd_addr != 5'd0);
  assign rd_clk = CLK & wr_en;

  assign illegal_seen_d = illegal_seen_q | illegal;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      illegal_seen_q <= 1'b0;
    end else begin
      illegal_seen_q <= illegal_seen_d;
    end
  end

  assign illegal_seen = illegal_seen_q;

endmodule

// File: tb/tb_decoder_r_insn.sv
// Directed-vector bench for decoder_r_insn: table of instructions plus reset sequences.
module tb_decoder_r_insn;

  logic        CLK;
  logic        RST;
  logic [31:0] INSN;
  logic        sub_sra, addr_sel, pc_next_sel, pc_alu_sel, rd_clk, mem_clk;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [2:0]  alu_op;
  logic        illegal, illegal_seen;

  decoder_r_insn dut (
    .CLK         (CLK),
    .RST         (RST),
    .INSN        (INSN),
    .sub_sra     (sub_sra),
    .addr_sel    (addr_sel),
    .pc_next_sel (pc_next_sel),
    .pc_alu_sel  (pc_alu_sel),
    .rd_clk      (rd_clk),
    .mem_clk     (mem_clk),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rd_addr     (rd_addr),
    .alu_op      (alu_op),
    .illegal     (illegal),
    .illegal_seen(illegal_seen)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] insn;
    logic        sub_sra;
    logic        illegal;
    logic        wr;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  alu_op;
  } vec_t;

  vec_t vecs[14];
  int   n_vec;
  int   n_bad;
  logic seen_exp;

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [4:0] rs2,
                                     input logic [4:0] rs1, input logic [2:0] f3,
                                     input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tieoffs_zero(input string name);
    chk(name, {28'd0, addr_sel, pc_next_sel, pc_alu_sel, mem_clk}, 32'd0);
  endtask

  initial begin
    n_vec    = 0;
    n_bad    = 0;
    seen_exp = 1'b0;

    vecs[0]  = '{32'h00F100B3, 1'b0, 1'b0, 1'b1, 5'd2,  5'd15, 5'd1,  3'd0};
    vecs[1]  = '{32'h402A00B3, 1'b1, 1'b0, 1'b1, 5'd20, 5'd2,  5'd1,  3'd0};
    vecs[2]  = '{32'h4020D0B3, 1'b1, 1'b0, 1'b1, 5'd1,  5'd2,  5'd1,  3'd5};
    vecs[3]  = '{32'h00F10033, 1'b0, 1'b0, 1'b0, 5'd2,  5'd15, 5'd0,  3'd0};
    vecs[4]  = '{mk(7'h00, 5'd3, 5'd4, 3'd4, 5'd5, 7'h33),    1'b0, 1'b0, 1'b1, 5'd4,  5'd3,  5'd5,  3'd4};
    vecs[5]  = '{mk(7'h00, 5'd31, 5'd31, 3'd7, 5'd31, 7'h33), 1'b0, 1'b0, 1'b1, 5'd31, 5'd31, 5'd31, 3'd7};
    vecs[6]  = '{mk(7'h00, 5'd6, 5'd7, 3'd1, 5'd8, 7'h33),    1'b0, 1'b0, 1'b1, 5'd7,  5'd6,  5'd8,  3'd1};
    vecs[7]  = '{mk(7'h00, 5'd6, 5'd7, 3'd5, 5'd8, 7'h33),    1'b0, 1'b0, 1'b1, 5'd7,  5'd6,  5'd8,  3'd5};
    vecs[8]  = '{mk(7'h20, 5'd6, 5'd7, 3'd5, 5'd0, 7'h33),    1'b1, 1'b0, 1'b0, 5'd7,  5'd6,  5'd0,  3'd5};
    vecs[9]  = '{32'h402170B3, 1'b0, 1'b1, 1'b0, 5'd2,  5'd2,  5'd1,  3'd7};
    vecs[10] = '{mk(7'h01, 5'd2, 5'd3, 3'd0, 5'd4, 7'h33),    1'b0, 1'b1, 1'b0, 5'd3,  5'd2,  5'd4,  3'd0};
    vecs[11] = '{mk(7'h20, 5'd2, 5'd3, 3'd1, 5'd4, 7'h33),    1'b0, 1'b1, 1'b0, 5'd3,  5'd2,  5'd4,  3'd1};
    vecs[12] = '{mk(7'h00, 5'd2, 5'd3, 3'd0, 5'd4, 7'h13),    1'b0, 1'b1, 1'b0, 5'd3,  5'd2,  5'd4,  3'd0};
    vecs[13] = '{mk(7'h00, 5'd9, 5'd10, 3'd2, 5'd11, 7'h33),  1'b0, 1'b0, 1'b1, 5'd10, 5'd9,  5'd11, 3'd2};

    // Reset state, with an illegal word present across a rising edge.
    RST  = 1'b1;
    INSN = 32'h402170B3;
    @(posedge CLK); #2;
    chk("rst_seen", {31'd0, illegal_seen}, 32'd0);
    chk("rst_rd_clk", {31'd0, rd_clk}, 32'd0);
    chk("rst_illegal_comb", {31'd0, illegal}, 32'd1);
    tieoffs_zero("rst_tieoffs");
    INSN = 32'h00F100B3;
    @(posedge CLK); #2;
    chk("rst_rd_clk_legal", {31'd0, rd_clk}, 32'd0);
    @(negedge CLK); #1;
    RST = 1'b0;

    foreach (vecs[i]) begin
      @(negedge CLK); #1;
      INSN = vecs[i].insn;
      @(posedge CLK); #2;
      if (!vecs[i].illegal) begin
        // seen_exp unchanged
      end else begin
        seen_exp = 1'b1;
      end
      chk($sformatf("v%0d_sub_sra", i), {31'd0, sub_sra}, {31'd0, vecs[i].sub_sra});
      chk($sformatf("v%0d_illegal", i), {31'd0, illegal}, {31'd0, vecs[i].illegal});
      chk($sformatf("v%0d_rd_clk_hi", i), {31'd0, rd_clk}, {31'd0, vecs[i].wr});
      chk($sformatf("v%0d_rs1", i), {27'd0, rs1_addr}, {27'd0, vecs[i].rs1});
      chk($sformatf("v%0d_rs2", i), {27'd0, rs2_addr}, {27'd0, vecs[i].rs2});
      chk($sformatf("v%0d_rd", i), {27'd0, rd_addr}, {27'd0, vecs[i].rd});
      chk($sformatf("v%0d_alu_op", i), {29'd0, alu_op}, {29'd0, vecs[i].alu_op});
      tieoffs_zero($sformatf("v%0d_tieoffs", i));
      chk($sformatf("v%0d_seen", i), {31'd0, illegal_seen}, {31'd0, seen_exp});
      @(negedge CLK); #2;
      chk($sformatf("v%0d_rd_clk_lo", i), {31'd0, rd_clk}, 32'd0);
    end

    // Async reset mid-cycle while CLK is high.
    @(negedge CLK); #1;
    INSN = 32'h402A00B3;
    @(posedge CLK); #2;
    chk("pre_rst_rd_clk", {31'd0, rd_clk}, 32'd1);
    chk("pre_rst_seen", {31'd0, illegal_seen}, 32'd1);
    RST = 1'b1;
    #1;
    chk("midrst_rd_clk", {31'd0, rd_clk}, 32'd0);
    chk("midrst_seen", {31'd0, illegal_seen}, 32'd0);
    chk("midrst_sub_sra", {31'd0, sub_sra}, 32'd1);
    chk("midrst_rs1", {27'd0, rs1_addr}, 32'd20);
    @(negedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #2;
    chk("postrst_rd_clk_hi", {31'd0, rd_clk}, 32'd1);
    chk("postrst_seen", {31'd0, illegal_seen}, 32'd0);
    @(negedge CLK); #2;
    chk("postrst_rd_clk_lo", {31'd0, rd_clk}, 32'd0);

    // First rise after release sets the sticky flag for an illegal word.
    @(negedge CLK); #1;
    RST  = 1'b1;
    INSN = 32'h402170B3;
    @(negedge CLK); #1;
    RST = 1'b0;
    #1;
    chk("release_seen_before_edge", {31'd0, illegal_seen}, 32'd0);
    @(posedge CLK); #2;
    chk("release_seen_after_edge", {31'd0, illegal_seen}, 32'd1);
    @(negedge CLK); #1;
    INSN = 32'h00F100B3;
    @(posedge CLK); #2;
    chk("sticky_seen", {31'd0, illegal_seen}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
